flash_loader: RTL and testbench

// - Host-side writer for the core's program-load port: takes a framed byte stream (from a UART RX or a testbench) and

---
 rtl/flash_loader_pkg.sv | 6 +
 rtl/flash_loader_byte_packer.sv | 38 +++
 rtl/flash_loader.sv | 144 ++++++++++++++
 tb/tb_flash_loader.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/flash_loader_pkg.sv
// flash_loader_pkg: shared loader states and framing constants
package flash_loader_pkg;
  typedef enum logic [2:0] {IDLE, CNT_LO, CNT_HI, DATA, CHK, FINISH} loader_state_t;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/flash_loader_byte_packer.sv
// byte_packer: packs a byte stream little-endian into 32-bit words with a one-cycle word strobe
module byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output logic [31:0] word
);
  logic [1:0]  lane_q, lane_d;
  logic [23:0] sr_q, sr_d;
  logic [31:0] word_q, word_d;
  logic        wv_q, wv_d;
  // shift bytes in from the top so the first byte ends up in bits [7:0]; word holds between strobes
  always_comb begin
    lane_d = clear ? 2'd0 : byte_en ? lane_q + 2'd1 : lane_q;
    sr_d   = byte_en ? {byte_in, sr_q[23:8]} : sr_q;
    wv_d   = byte_en && !clear && lane_q == 2'd3;
    word_d = wv_d ? {byte_in, sr_q} : word_q;
  end
  // lane counter, shift register and output word
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q <= '0;
      sr_q   <= '0;
      word_q <= '0;
      wv_q   <= 1'b0;
    end else begin
      lane_q <= lane_d;
      sr_q   <= sr_d;
      word_q <= word_d;
      wv_q   <= wv_d;
    end
  end
  assign word_valid = wv_q;
  assign word       = word_q;
endmodule

// File: rtl/flash_loader.sv
// flash_loader: framed byte stream to core flash writes; FLASH_LOADER_CHECKSUM_EN adds a trailing XOR check byte
module flash_loader
  import flash_loader_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] BASE_ADDR = '0,
  parameter int               MAX_WORDS = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  output logic             rx_ready,
  output logic             flash_en,
  output logic [WIDTH-1:0] flash_addr,
  output logic [WIDTH-1:0] flash_data,
  output logic             core_rst,
  output logic             busy,
  output logic             done,
  output logic             err
);
`ifdef FLASH_LOADER_CHECKSUM_EN
  localparam loader_state_t LAST = CHK;
  logic [7:0] chk_q, chk_d;
`else
  localparam loader_state_t LAST = FINISH;
`endif
  loader_state_t    state_q, state_d;
  logic             rdy_q, core_rst_q, core_rst_d, err_q, err_d;
  logic [15:0]      n_q, n_d;
  logic [WIDTH-1:0] idx_q, idx_d, addr_q, addr_d;
  logic [1:0]       bc_q, bc_d;
  logic             take, clear, byte_en, word_valid;
  logic [31:0]      word;
  assign take = rx_valid && rdy_q;
  byte_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .byte_en   (byte_en),
    .byte_in   (rx_data),
    .word_valid(word_valid),
    .word      (word)
  );
  // frame parser: sync, 16-bit word count, data bytes, optional check byte, then release the core
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    idx_d      = idx_q;
    bc_d       = bc_q;
    addr_d     = addr_q;
    err_d      = err_q;
    core_rst_d = core_rst_q;
    clear      = 1'b0;
    byte_en    = 1'b0;
`ifdef FLASH_LOADER_CHECKSUM_EN
    chk_d      = chk_q;
`endif
    unique case (state_q)
      IDLE: if (take && rx_data == SYNC_BYTE) begin
        state_d    = CNT_LO;
        core_rst_d = 1'b1;
        err_d      = 1'b0;
        clear      = 1'b1;
`ifdef FLASH_LOADER_CHECKSUM_EN
        chk_d      = '0;
`endif
      end
      CNT_LO: if (take) begin
        n_d     = {8'd0, rx_data};
        state_d = CNT_HI;
      end
      CNT_HI: if (take) begin
        n_d   = {rx_data, n_q[7:0]};
        idx_d = '0;
        bc_d  = '0;
        if (n_d == 16'd0) state_d = LAST;
        else if (32'(n_d) > 32'(MAX_WORDS)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else state_d = DATA;
      end
      DATA: if (take) begin
        byte_en = 1'b1;
        bc_d    = bc_q + 2'd1;
`ifdef FLASH_LOADER_CHECKSUM_EN
        chk_d   = chk_q ^ rx_data;
`endif
        if (bc_q == 2'(BYTES_PER_WORD - 1)) begin
          addr_d = BASE_ADDR + (idx_q << 2);
          idx_d  = idx_q + 1'b1;
          if (idx_d == WIDTH'(n_q)) state_d = LAST;
        end
      end
`ifdef FLASH_LOADER_CHECKSUM_EN
      CHK: if (take) begin
        state_d = rx_data == chk_q ? FINISH : IDLE;
        err_d   = rx_data != chk_q;
      end
`endif
      FINISH: begin
        core_rst_d = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers; rx_ready rises on the first cycle out of reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rdy_q      <= 1'b0;
      core_rst_q <= 1'b1;
      err_q      <= 1'b0;
      n_q        <= '0;
      idx_q      <= '0;
      bc_q       <= '0;
      addr_q     <= '0;
`ifdef FLASH_LOADER_CHECKSUM_EN
      chk_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rdy_q      <= 1'b1;
      core_rst_q <= core_rst_d;
      err_q      <= err_d;
      n_q        <= n_d;
      idx_q      <= idx_d;
      bc_q       <= bc_d;
      addr_q     <= addr_d;
`ifdef FLASH_LOADER_CHECKSUM_EN
      chk_q      <= chk_d;
`endif
    end
  end
  assign rx_ready   = rdy_q;
  assign flash_en   = word_valid;
  assign flash_addr = addr_q;
  assign flash_data = WIDTH'(word);
  assign core_rst   = core_rst_q && state_q != FINISH;
  assign busy       = state_q != IDLE;
  assign done       = state_q == FINISH;
  assign err        = err_q;
endmodule

// File: tb/tb_flash_loader.sv
// tb_flash_loader: directed and random frames checked against a frame-level reference model
module tb_flash_loader;
  import flash_loader_pkg::*;
  localparam int          MAXW = 1024;
  localparam logic [31:0] BASE = 32'h0;
`ifdef FLASH_LOADER_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, rx_valid = 1'b0;
  logic [7:0] rx_data = '0;
  logic rx_ready, flash_en, core_rst, busy, done, err;
  logic [31:0] flash_addr, flash_data;
  logic [63:0] obs_q[$];
  logic [7:0]  data_q[$];
  int done_cnt = 0;
  int checks = 0, errors = 0;
  int w0;

  flash_loader #(.WIDTH(32), .BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .flash_en(flash_en), .flash_addr(flash_addr), .flash_data(flash_data),
    .core_rst(core_rst), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // monitor: log every write and done pulse away from the active edge
  always @(negedge clk) begin
    if (flash_en) obs_q.push_back({flash_addr, flash_data});
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    repeat (gap) @(negedge clk);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic fill(input int n);
    data_q.delete();
    for (int i = 0; i < 4 * n; i++) data_q.push_back(8'($urandom));
  endtask

  task automatic garbage(input int k);
    logic [7:0] b;
    for (int i = 0; i < k; i++) begin
      b = 8'($urandom);
      if (b == SYNC_BYTE) b = 8'h00;
      send(b, 0);
    end
  endtask

  // send one frame built from data_q and compare everything it should produce
  task automatic run_frame(input logic [15:0] n, input bit bad_chk, input int gap_max, input string tag);
    int s0, d0, nw;
    logic [7:0] x;
    logic [31:0] w;
    bit ok;
    s0 = obs_q.size();
    d0 = done_cnt;
    x  = '0;
    send(SYNC_BYTE, $urandom_range(gap_max, 0));
    send(n[7:0], $urandom_range(gap_max, 0));
    send(n[15:8], $urandom_range(gap_max, 0));
    if (int'(n) <= MAXW) begin
      for (int i = 0; i < 4 * int'(n); i++) begin
        send(data_q[i], $urandom_range(gap_max, 0));
        x ^= data_q[i];
      end
      if (CHK_EN) send(bad_chk ? x ^ 8'h44 : x, $urandom_range(gap_max, 0));
    end
    repeat (3) @(negedge clk);
    ok = int'(n) <= MAXW && !(CHK_EN && bad_chk);
    nw = int'(n) <= MAXW ? int'(n) : 0;
    check({tag, "/nwrites"}, 64'(obs_q.size() - s0), 64'(nw));
    for (int i = 0; i < nw && s0 + i < obs_q.size(); i++) begin
      w = {data_q[4*i+3], data_q[4*i+2], data_q[4*i+1], data_q[4*i]};
      check({tag, "/write"}, obs_q[s0+i], {BASE + 32'(4 * i), w});
    end
    check({tag, "/done"}, 64'(done_cnt - d0), ok ? 64'd1 : 64'd0);
    check({tag, "/err"}, 64'(err), 64'(!ok));
    check({tag, "/core_rst"}, 64'(core_rst), 64'(!ok));
    check({tag, "/busy"}, 64'(busy), 64'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "/rx_ready"}, 64'(rx_ready), 64'd0);
    check({tag, "/flash_en"}, 64'(flash_en), 64'd0);
    check({tag, "/flash_addr"}, 64'(flash_addr), 64'd0);
    check({tag, "/flash_data"}, 64'(flash_data), 64'd0);
    check({tag, "/core_rst"}, 64'(core_rst), 64'd1);
    check({tag, "/busy"}, 64'(busy), 64'd0);
    check({tag, "/done"}, 64'(done), 64'd0);
    check({tag, "/err"}, 64'(err), 64'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 64'(rx_ready), 64'd1);

    data_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    w0 = obs_q.size();
    run_frame(16'd2, 1'b0, 0, "basic");
    check("basic/w0_literal", obs_q[w0], {32'h0, 32'h44332211});
    check("basic/w1_literal", obs_q[w0+1], {32'h4, 32'h88776655});

    garbage(0);
    send(8'h00, 0);
    send(8'hFF, 0);
    send(8'h13, 0);
    run_frame(16'd2, 1'b0, 0, "garbage");

    run_frame(16'h0401, 1'b0, 0, "oversize");
    fill(3);
    run_frame(16'd3, 1'b0, 1, "after_oversize");

    fill(2);
    w0 = obs_q.size();
    send(SYNC_BYTE, 0);
    send(8'h02, 0);
    send(8'h00, 0);
    for (int i = 0; i < 6; i++) send(data_q[i], 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("midrst");
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("midrst/nwrites", 64'(obs_q.size() - w0), 64'd1);
    check("midrst/word0", obs_q[w0], {BASE, data_q[3], data_q[2], data_q[1], data_q[0]});
    fill(2);
    run_frame(16'd2, 1'b0, 0, "after_midrst");

`ifdef FLASH_LOADER_CHECKSUM_EN
    data_q = '{8'h44, 8'h00, 8'h00, 8'h00};
    run_frame(16'd1, 1'b1, 0, "bad_chk");
`endif

    data_q.delete();
    run_frame(16'd0, 1'b0, 0, "n0");

    for (int t = 0; t < 25; t++) begin
      logic [15:0] n;
      n = ($urandom_range(7, 0) == 0) ? 16'(MAXW + 1 + $urandom_range(5, 0)) : 16'($urandom_range(6, 0));
      fill(int'(n) <= MAXW ? int'(n) : 0);
      garbage($urandom_range(3, 0));
      run_frame(n, 1'($urandom_range(1, 0)), 2, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
